// File: rtl/pipe_reg_file.sv
// -----------------------------------------------------------------------------
// pipe_reg_file
// Pipeline register file with two combinational read ports, one writeback
// port with write-through bypass, and a per-register pending-write counter
// (scoreboard) used to flag reads of registers whose data is still in flight.
//
// Ports
//   iCpuClock     : clock, all state updates on the rising edge
//   iCpuReset     : asynchronous active-high reset
//   iReadAddr1/2  : read port indices
//   oReadData1/2  : read port data (bypassed from the writeback port)
//   oReadBusy1/2  : read register still has an outstanding write this cycle
//   iIssueValid   : reserve a future write to iIssueDest
//   iIssueDest    : destination index being reserved
//   oIssueReject  : reservation refused (counter saturated, no writeback)
//   iWriteEnable  : writeback strobe
//   iWriteAddr    : writeback destination index
//   iWriteData    : writeback data
//   oAnyPending   : registered flag, some counter is non-zero
// -----------------------------------------------------------------------------
module pipe_reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int PEND_WIDTH = 2
) (
   input  logic                  iCpuClock,
   input  logic                  iCpuReset,
   input  logic [ADDR_WIDTH-1:0] iReadAddr1,
   input  logic [ADDR_WIDTH-1:0] iReadAddr2,
   output logic [DATA_WIDTH-1:0] oReadData1,
   output logic [DATA_WIDTH-1:0] oReadData2,
   output logic                  oReadBusy1,
   output logic                  oReadBusy2,
   input  logic                  iIssueValid,
   input  logic [ADDR_WIDTH-1:0] iIssueDest,
   output logic                  oIssueReject,
   input  logic                  iWriteEnable,
   input  logic [ADDR_WIDTH-1:0] iWriteAddr,
   input  logic [DATA_WIDTH-1:0] iWriteData,
   output logic                  oAnyPending
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] PEND_MAX  = {PEND_WIDTH{1'b1}};
   localparam logic [PEND_WIDTH-1:0] PEND_ZERO = {PEND_WIDTH{1'b0}};
   localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regFile_r   [DEPTH];
   logic [PEND_WIDTH-1:0] pendCount_r [DEPTH];
   logic [PEND_WIDTH-1:0] pendNext_s  [DEPTH];
   logic                  anyPending_r;
   logic                  anyNext_s;
   logic                  writeHit_s;
   logic                  issueBypass_s;
   logic                  issueAccept_s;
   logic                  issueReject_s;

   // Read value for one port: register 0 is hard zero, a same-cycle
   // writeback to the read index is forwarded ahead of the stored value.
   function automatic logic [DATA_WIDTH-1:0] readValue(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  wrHit,
      input logic [ADDR_WIDTH-1:0] wrAddr,
      input logic [DATA_WIDTH-1:0] wrData,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] value;
      if (addr == ADDR_ZERO) begin
         value = DATA_ZERO;
      end else if (wrHit && (wrAddr == addr)) begin
         value = wrData;
      end else begin
         value = stored;
      end
      return value;
   endfunction

   // Busy for one port: a count of exactly one is satisfied by a same-cycle
   // writeback to that index, so the reader sees the bypassed data instead.
   function automatic logic readBusy(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [PEND_WIDTH-1:0] count,
      input logic                  wrHit,
      input logic [ADDR_WIDTH-1:0] wrAddr
   );
      logic busy;
      if (addr == ADDR_ZERO) begin
         busy = 1'b0;
      end else if (count == PEND_ZERO) begin
         busy = 1'b0;
      end else if ((count == PEND_ONE) && wrHit && (wrAddr == addr)) begin
         busy = 1'b0;
      end else begin
         busy = 1'b1;
      end
      return busy;
   endfunction

   // Issue/writeback qualification; index 0 is neither tracked nor written.
   always_comb begin
      writeHit_s    = iWriteEnable && (iWriteAddr != ADDR_ZERO);
      issueBypass_s = writeHit_s && (iWriteAddr == iIssueDest);
      issueReject_s = 1'b0;
      issueAccept_s = 1'b0;
      if (iIssueValid && (iIssueDest != ADDR_ZERO)) begin
         // A saturated counter can still take an issue when the same index
         // retires a write this cycle; the two cancel out.
         if ((pendCount_r[iIssueDest] == PEND_MAX) && !issueBypass_s) begin
            issueReject_s = 1'b1;
         end else begin
            issueAccept_s = 1'b1;
         end
      end else begin
         issueReject_s = 1'b0;
         issueAccept_s = 1'b0;
      end
   end

   // Next pending count per register and the OR that feeds oAnyPending.
   always_comb begin
      anyNext_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         pendNext_s[i] = pendCount_r[i];
         if (i == 0) begin
            pendNext_s[i] = PEND_ZERO;
         end else begin
            case ({issueAccept_s && (iIssueDest == ADDR_WIDTH'(i)),
                   writeHit_s    && (iWriteAddr == ADDR_WIDTH'(i))})
               2'b10: pendNext_s[i] = pendCount_r[i] + PEND_ONE;
               2'b01: begin
                  // Untracked writes leave a zero counter at zero.
                  if (pendCount_r[i] != PEND_ZERO) begin
                     pendNext_s[i] = pendCount_r[i] - PEND_ONE;
                  end else begin
                     pendNext_s[i] = PEND_ZERO;
                  end
               end
               2'b11:   pendNext_s[i] = pendCount_r[i];
               default: pendNext_s[i] = pendCount_r[i];
            endcase
         end
         anyNext_s = anyNext_s | (pendNext_s[i] != PEND_ZERO);
      end
   end

   // Register storage, pending counters and the pending summary flag.
   always_ff @(posedge iCpuClock or posedge iCpuReset) begin
      if (iCpuReset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regFile_r[i]   <= DATA_ZERO;
            pendCount_r[i] <= PEND_ZERO;
         end
         anyPending_r <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pendCount_r[i] <= pendNext_s[i];
         end
         if (writeHit_s) begin
            regFile_r[iWriteAddr] <= iWriteData;
         end
         anyPending_r <= anyNext_s;
      end
   end

   assign oReadData1   = readValue(iReadAddr1, writeHit_s, iWriteAddr, iWriteData,
                                   regFile_r[iReadAddr1]);
   assign oReadData2   = readValue(iReadAddr2, writeHit_s, iWriteAddr, iWriteData,
                                   regFile_r[iReadAddr2]);
   assign oReadBusy1   = readBusy(iReadAddr1, pendCount_r[iReadAddr1], writeHit_s, iWriteAddr);
   assign oReadBusy2   = readBusy(iReadAddr2, pendCount_r[iReadAddr2], writeHit_s, iWriteAddr);
   assign oIssueReject = issueReject_s;
   assign oAnyPending  = anyPending_r;

endmodule

// File: tb/tb_pipe_reg_file.sv
module tb_pipe_reg_file;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int PMAX  = 3;

   logic          iCpuClock;
   logic          iCpuReset;
   logic [AW-1:0] iReadAddr1;
   logic [AW-1:0] iReadAddr2;
   logic [DW-1:0] oReadData1;
   logic [DW-1:0] oReadData2;
   logic          oReadBusy1;
   logic          oReadBusy2;
   logic          iIssueValid;
   logic [AW-1:0] iIssueDest;
   logic          oIssueReject;
   logic          iWriteEnable;
   logic [AW-1:0] iWriteAddr;
   logic [DW-1:0] iWriteData;
   logic          oAnyPending;

   int checks   = 0;
   int failures = 0;

   // reference model: architectural register values and outstanding writes
   logic [DW-1:0] mReg [DEPTH];
   int            mCnt [DEPTH];
   logic          mAny;

   pipe_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PEND_WIDTH(2)) dut (
      .iCpuClock   (iCpuClock),
      .iCpuReset   (iCpuReset),
      .iReadAddr1  (iReadAddr1),
      .iReadAddr2  (iReadAddr2),
      .oReadData1  (oReadData1),
      .oReadData2  (oReadData2),
      .oReadBusy1  (oReadBusy1),
      .oReadBusy2  (oReadBusy2),
      .iIssueValid (iIssueValid),
      .iIssueDest  (iIssueDest),
      .oIssueReject(oIssueReject),
      .iWriteEnable(iWriteEnable),
      .iWriteAddr  (iWriteAddr),
      .iWriteData  (iWriteData),
      .oAnyPending (oAnyPending)
   );

   initial iCpuClock = 1'b0;
   always #5 iCpuClock = ~iCpuClock;

   task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) begin
         mReg[i] = '0;
         mCnt[i] = 0;
      end
      mAny = 1'b0;
   endtask

   // One clock cycle: drive, check combinational outputs against the model,
   // advance the model, cross the edge, check the registered flag.
   task automatic cycle(input logic iv, input logic [AW-1:0] idest,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
      logic          wbHit, rej, acc;
      logic [DW-1:0] expRd1, expRd2;
      logic          expB1, expB2;
      iIssueValid = iv;  iIssueDest = idest;
      iWriteEnable = we; iWriteAddr = wa; iWriteData = wd;
      iReadAddr1 = ra1;  iReadAddr2 = ra2;
      #1;
      wbHit  = we && (wa != 0);
      expRd1 = (ra1 == 0) ? '0 : ((wbHit && wa == ra1) ? wd : mReg[ra1]);
      expRd2 = (ra2 == 0) ? '0 : ((wbHit && wa == ra2) ? wd : mReg[ra2]);
      expB1  = (ra1 != 0) && (mCnt[ra1] > 0) && !(mCnt[ra1] == 1 && wbHit && wa == ra1);
      expB2  = (ra2 != 0) && (mCnt[ra2] > 0) && !(mCnt[ra2] == 1 && wbHit && wa == ra2);
      rej    = iv && (idest != 0) && (mCnt[idest] == PMAX) && !(wbHit && wa == idest);
      check("readData1", oReadData1, expRd1);
      check("readData2", oReadData2, expRd2);
      check("readBusy1", {31'd0, oReadBusy1}, {31'd0, expB1});
      check("readBusy2", {31'd0, oReadBusy2}, {31'd0, expB2});
      check("issueReject", {31'd0, oIssueReject}, {31'd0, rej});
      acc = iv && (idest != 0) && !rej;
      if (wbHit) mReg[wa] = wd;
      if (!(acc && wbHit && wa == idest)) begin
         if (acc) mCnt[idest] = mCnt[idest] + 1;
         if (wbHit && mCnt[wa] > 0) mCnt[wa] = mCnt[wa] - 1;
      end
      mAny = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (mCnt[i] != 0) mAny = 1'b1;
      @(posedge iCpuClock);
      #1;
      check("anyPending", {31'd0, oAnyPending}, {31'd0, mAny});
   endtask

   initial begin
      iCpuReset = 1'b1;
      iIssueValid = 1'b0; iIssueDest = '0;
      iWriteEnable = 1'b0; iWriteAddr = '0; iWriteData = '0;
      iReadAddr1 = 5'd5; iReadAddr2 = 5'd9;
      modelReset();
      @(posedge iCpuClock); @(posedge iCpuClock); #1;
      check("rst_anyPending", {31'd0, oAnyPending}, 32'd0);
      check("rst_data1", oReadData1, 32'd0);
      check("rst_busy2", {31'd0, oReadBusy2}, 32'd0);
      iCpuReset = 1'b0;

      // write r5, read it back next cycle
      cycle(1'b0, 5'd0, 1'b1, 5'd5, 32'h12345678, 5'd1, 5'd2);
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
      iReadAddr1 = 5'd5; #1;
      check("r5_const", oReadData1, 32'h12345678);

      // register 0 ignores writes and issues
      cycle(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      cycle(1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      check("r0_noPend", {31'd0, oAnyPending}, 32'd0);

      // issue r3, busy next cycle, last write clears busy with bypass
      cycle(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      cycle(1'b0, 5'd0, 1'b1, 5'd3, 32'hA5, 5'd3, 5'd0);
      check("r3_drained", {31'd0, oAnyPending}, 32'd0);

      // saturate r7, reject, then issue alongside writeback
      repeat (3) cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
      cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
      cycle(1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
      cycle(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      repeat (3) cycle(1'b0, 5'd0, 1'b1, 5'd7, 32'h78, 5'd7, 5'd7);

      // issue r9 twice, then reset asynchronously mid-cycle
      cycle(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
      cycle(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
      cycle(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
      iIssueValid = 1'b0; iWriteEnable = 1'b0;
      iReadAddr1 = 5'd9; iReadAddr2 = 5'd9;
      #3;
      iCpuReset = 1'b1;
      #1;
      modelReset();
      check("arst_anyPending", {31'd0, oAnyPending}, 32'd0);
      check("arst_busy1", {31'd0, oReadBusy1}, 32'd0);
      check("arst_data1", oReadData1, 32'd0);
      @(posedge iCpuClock); #1;
      iCpuReset = 1'b0;

      // untracked write to r4, then issue+write same cycle
      cycle(1'b0, 5'd0, 1'b1, 5'd4, 32'hCAFE0004, 5'd4, 5'd0);
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      cycle(1'b1, 5'd4, 1'b1, 5'd4, 32'hBEEF0004, 5'd0, 5'd4);
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      iReadAddr1 = 5'd4; #1;
      check("r4_const", oReadData1, 32'hBEEF0004);

      // randomized traffic, indices concentrated to force collisions
      for (int n = 0; n < 500; n++) begin
         logic [AW-1:0] d, w, r1, r2;
         d  = AW'($urandom_range(0, 7));
         w  = AW'($urandom_range(0, 7));
         r1 = AW'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
         cycle(($urandom_range(0, 2) != 0), d, ($urandom_range(0, 1) != 0), w, $urandom(), r1, r2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
